// File: rtl/inst_cache_pkg.sv
// Shared geometry constants and FSM encoding for the direct-mapped instruction cache.
// Every other cache file imports this package.
package inst_cache_pkg;

   localparam int ICACHE_INDEX_BITS  = 4;
   localparam int ICACHE_OFFSET_BITS = 4;
   localparam int ICACHE_ADDR_WIDTH  = 32;
   localparam int ICACHE_WORDS       = 1 << (ICACHE_OFFSET_BITS - 2);
   localparam int ICACHE_TAG_BITS    = ICACHE_ADDR_WIDTH - ICACHE_INDEX_BITS - ICACHE_OFFSET_BITS;

   typedef enum logic {
      IC_IDLE = 1'b0,
      IC_FILL = 1'b1
   } ic_state_e;

   // A one-word line still needs a one-bit counter so that no vector is zero width.
   function automatic int ic_cnt_width(input int offset_bits);
      return (offset_bits > 2) ? offset_bits - 2 : 1;
   endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetcher-side and memory-controller-side signals of the instruction cache.
// The cache uses the slave modport; the fetcher/controller environment uses master.
interface inst_cache_if
   import inst_cache_pkg::*;
#(
   parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH
);

   logic                  need_inst;
   logic [ADDR_WIDTH-1:0] pc_in;
   logic                  inst_ready_out;
   logic [31:0]           inst_out;
   logic                  inv_all;
   logic                  mc_req;
   logic [ADDR_WIDTH-1:0] mc_addr;
   logic                  mc_data_valid;
   logic [31:0]           mc_data;

   modport slave (
      input  need_inst, pc_in, inv_all, mc_data_valid, mc_data,
      output inst_ready_out, inst_out, mc_req, mc_addr
   );

   modport master (
      output need_inst, pc_in, inv_all, mc_data_valid, mc_data,
      input  inst_ready_out, inst_out, mc_req, mc_addr
   );

endinterface

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: synchronous writes,
// combinational read of one word, per-line clear and invalidate-all.
module inst_cache_array
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = ICACHE_TAG_BITS,
   parameter int WORDS      = ICACHE_WORDS,
   parameter int CNT_W      = ic_cnt_width(ICACHE_OFFSET_BITS)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [INDEX_BITS-1:0] rd_index_i,
   input  logic [CNT_W-1:0]      rd_wsel_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [31:0]           rd_word_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_index_i,
   input  logic [CNT_W-1:0]      wr_wsel_i,
   input  logic [31:0]           wr_word_i,
   input  logic                  install_i,
   input  logic [TAG_BITS-1:0]   install_tag_i,
   input  logic                  clr_en_i,
   input  logic [INDEX_BITS-1:0] clr_index_i,
   input  logic                  inv_all_i
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES][WORDS];

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_word_o  = data_q[rd_index_i][rd_wsel_i];

   // Invalidate-all wins over an install in the same cycle so a pending fence.i
   // also kills the line that is just being completed.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= '0;
      end else if (inv_all_i) begin
         valid_q <= '0;
      end else begin
         if (clr_en_i)  valid_q[clr_index_i] <= 1'b0;
         if (install_i) valid_q[wr_index_i]  <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (install_i) tag_q[wr_index_i] <= install_tag_i;
      if (wr_en_i)   data_q[wr_index_i][wr_wsel_i] <= wr_word_i;
   end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line
// fills from the memory controller one word per beat.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
   parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
   parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   inst_cache_if.slave  bus
);

   localparam int WORDS   = 1 << (OFFSET_BITS - 2);
   localparam int CNT_W   = ic_cnt_width(OFFSET_BITS);
   localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int TAG_LSB = OFFSET_BITS + INDEX_BITS;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   ic_state_e             state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  mc_req_q;
   logic [ADDR_WIDTH-1:0] mc_addr_q;
   logic                  inv_pend_q;

   logic [INDEX_BITS-1:0] pc_index, fill_index;
   logic [TAG_W-1:0]      pc_tag, fill_tag, rd_tag;
   logic [CNT_W-1:0]      pc_wsel;
   logic                  rd_valid;
   logic [31:0]           rd_word;
   logic                  lookup, tag_hit, hit, start_fill, inv_now, beat, last_beat;

   assign pc_index   = bus.pc_in[TAG_LSB-1:OFFSET_BITS];
   assign pc_tag     = bus.pc_in[ADDR_WIDTH-1:TAG_LSB];
   assign pc_wsel    = CNT_W'(bus.pc_in[OFFSET_BITS-1:0] >> 2);
   assign fill_index = mc_addr_q[TAG_LSB-1:OFFSET_BITS];
   assign fill_tag   = mc_addr_q[ADDR_WIDTH-1:TAG_LSB];

   // Invalidate-all in IDLE takes the cycle: no hit is reported and no fill starts.
   assign lookup     = rdy_in && bus.need_inst && (state_q == IC_IDLE);
   assign tag_hit    = rd_valid && (rd_tag == pc_tag);
   assign inv_now    = rdy_in && bus.inv_all && (state_q == IC_IDLE);
   assign hit        = lookup && tag_hit && !bus.inv_all;
   assign start_fill = lookup && !tag_hit && !bus.inv_all;
   assign beat       = rdy_in && (state_q == IC_FILL) && bus.mc_data_valid;
   assign last_beat  = beat && (cnt_q == LAST_WORD);

   assign bus.inst_ready_out = hit;
   assign bus.inst_out       = hit ? rd_word : 32'h0;
   assign bus.mc_req         = mc_req_q;
   assign bus.mc_addr        = mc_addr_q;

   inst_cache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_W),
      .WORDS      (WORDS),
      .CNT_W      (CNT_W)
   ) u_array (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rd_index_i    (pc_index),
      .rd_wsel_i     (pc_wsel),
      .rd_valid_o    (rd_valid),
      .rd_tag_o      (rd_tag),
      .rd_word_o     (rd_word),
      .wr_en_i       (beat),
      .wr_index_i    (fill_index),
      .wr_wsel_i     (cnt_q),
      .wr_word_i     (bus.mc_data),
      .install_i     (last_beat),
      .install_tag_i (fill_tag),
      .clr_en_i      (start_fill),
      .clr_index_i   (pc_index),
      .inv_all_i     (inv_now || (last_beat && (inv_pend_q || bus.inv_all)))
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IC_IDLE;
         cnt_q      <= '0;
         mc_req_q   <= 1'b0;
         mc_addr_q  <= '0;
         inv_pend_q <= 1'b0;
      end else if (rdy_in) begin
         case (state_q)
            IC_IDLE: begin
               if (start_fill) begin
                  state_q   <= IC_FILL;
                  mc_req_q  <= 1'b1;
                  mc_addr_q <= {pc_tag, pc_index, {OFFSET_BITS{1'b0}}};
                  cnt_q     <= '0;
               end
            end
            IC_FILL: begin
               if (bus.inv_all) inv_pend_q <= 1'b1;
               if (beat) cnt_q <= cnt_q + 1'b1;
               if (last_beat) begin
                  state_q    <= IC_IDLE;
                  mc_req_q   <= 1'b0;
                  cnt_q      <= '0;
                  inv_pend_q <= 1'b0;
               end
            end
            default: state_q <= IC_IDLE;
         endcase
      end
   end

endmodule
